mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_responder.sv | 107 ++++++++++
 tb/tb_mem_io_responder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus memory-mapped UART TX FIFO, RX holding register,
// cycle counter snapshot and sticky program-stop / overflow flags.
module mem_io_responder #(
  parameter int ADDR_W   = 17,
  parameter int TX_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [31:0] mem_a,
  input  logic [7:0]  mem_dout,
  input  logic        mem_wr,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);
  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(TX_DEPTH);
  localparam logic [PW:0] MARK  = (PW+1)'(TX_DEPTH - 2);

  logic [7:0]        ram  [2**ADDR_W];
  logic [7:0]        fifo [TX_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count, count_next;
  logic [31:0]       cyc, snap;
  logic [7:0]        held, io_rdata, push_data;
  logic              held_valid, run;
  logic              is_io, io_reg, rd, push, pop, full, acc;
  logic [2:0]        off;
  logic [ADDR_W-1:0] idx;
  logic              unused_hi;

  assign unused_hi = ^mem_a[31:18];
  assign is_io     = mem_a[17:16] == 2'b11;
  assign io_reg    = mem_a[17:3] == 15'h6000;
  assign off       = mem_a[2:0];
  assign idx       = mem_a[ADDR_W-1:0];
  // run masks the read presented on the first edge after reset release
  assign rd        = !mem_wr && run;
  assign push      = mem_wr && io_reg && !program_stop &&
                     (off == 3'd4 || (off == 3'd0 && mem_dout != 8'h00));
  assign push_data = off == 3'd4 ? 8'h00 : mem_dout;
  assign full      = count == DEPTH;
  assign tx_valid  = count != '0;
  assign tx_data   = fifo[rd_ptr];
  assign pop       = tx_valid && tx_ready;
  assign acc       = push && (!full || pop);
  assign rx_ready  = !held_valid;

  assign count_next = (acc && !pop) ? count + (PW+1)'(1) :
                      (!acc && pop) ? count - (PW+1)'(1) : count;

  assign io_rdata = !io_reg      ? 8'h00 :
                    off == 3'd0 ? (held_valid ? held : 8'h00) :
                    off == 3'd4 ? cyc[7:0] :
                    off == 3'd5 ? snap[15:8] :
                    off == 3'd6 ? snap[23:16] :
                    off == 3'd7 ? snap[31:24] : 8'h00;

  always_ff @(posedge clk_in) begin
    if (mem_wr && !is_io) ram[idx] <= mem_dout;
  end

  always_ff @(posedge clk_in) begin
    if (rst_n_in && acc) fifo[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_din        <= 8'h00;
      io_buffer_full <= 1'b0;
      program_stop   <= 1'b0;
      tx_overflow    <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      cyc            <= 32'd0;
      snap           <= 32'd0;
      held           <= 8'h00;
      held_valid     <= 1'b0;
      run            <= 1'b0;
    end else begin
      run <= 1'b1;
      cyc <= cyc + 32'd1;
      if (rd) mem_din <= is_io ? io_rdata : ram[idx];
      if (rd && io_reg && off == 3'd4) snap <= cyc;
      if (!held_valid && rx_valid) begin
        held       <= rx_data;
        held_valid <= 1'b1;
      end else if (held_valid && rd && io_reg && off == 3'd0) begin
        held_valid <= 1'b0;
      end
      if (acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count          <= count_next;
      io_buffer_full <= count_next >= MARK;
      if (push && full && !pop) tx_overflow <= 1'b1;
      if (mem_wr && io_reg && off == 3'd4) program_stop <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: directed plus random stimulus against a queue/array reference model.
module tb_mem_io_responder;
  localparam int D = 8;
  logic        clk_in = 1'b0, rst_n_in = 1'b0;
  logic [31:0] mem_a = 32'd0;
  logic [7:0]  mem_dout = 8'h00, rx_data = 8'h00;
  logic        mem_wr = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [7:0]  mem_din, tx_data;
  logic        io_buffer_full, tx_valid, rx_ready, program_stop, tx_overflow;

  mem_io_responder #(.ADDR_W(17), .TX_DEPTH(D)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  int          errors = 0, checks = 0, nstep = 0;
  logic [7:0]  m_ram [int];
  logic [7:0]  m_q [$];
  logic [7:0]  m_held = 8'h00, m_din = 8'h00;
  bit          m_hv, m_stop, m_ovf, m_first;
  logic [31:0] m_cyc = 32'd0, m_snap = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string s);
    chk({s, ":mem_din"}, {24'd0, mem_din}, {24'd0, m_din});
    chk({s, ":tx_valid"}, {31'd0, tx_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) chk({s, ":tx_data"}, {24'd0, tx_data}, {24'd0, m_q[0]});
    chk({s, ":io_buffer_full"}, {31'd0, io_buffer_full}, {31'd0, m_q.size() >= D - 2});
    chk({s, ":rx_ready"}, {31'd0, rx_ready}, {31'd0, !m_hv});
    chk({s, ":program_stop"}, {31'd0, program_stop}, {31'd0, m_stop});
    chk({s, ":tx_overflow"}, {31'd0, tx_overflow}, {31'd0, m_ovf});
  endtask

  // One bus cycle: drive at the falling edge, advance the model across the rising edge, check 1ns later.
  task automatic step(input logic [31:0] a, input logic [7:0] d, input logic w,
                      input logic txr = 1'b0, input logic [7:0] rxd = 8'h00, input logic rxv = 1'b0);
    logic [17:0] lo;
    logic        io, rg, pop, push, hv0;
    logic [2:0]  off;
    logic [7:0]  pd;
    int          sz;
    mem_a = a; mem_dout = d; mem_wr = w; tx_ready = txr; rx_data = rxd; rx_valid = rxv;
    lo  = a[17:0];
    io  = lo[17:16] == 2'b11;
    rg  = lo[17:3] == 15'h6000;
    off = lo[2:0];
    sz  = m_q.size();
    pop = sz != 0 && txr;
    hv0 = m_hv;
    push = w && rg && !m_stop && (off == 3'd4 || (off == 3'd0 && d != 8'h00));
    pd  = off == 3'd4 ? 8'h00 : d;
    @(posedge clk_in);
    if (w && !io) m_ram[int'(lo[16:0])] = d;
    if (!w && !m_first) begin
      if (!io) m_din = m_ram[int'(lo[16:0])];
      else if (!rg) m_din = 8'h00;
      else case (off)
        3'd0: begin m_din = hv0 ? m_held : 8'h00; m_hv = 1'b0; end
        3'd4: begin m_snap = m_cyc; m_din = m_cyc[7:0]; end
        3'd5: m_din = m_snap[15:8];
        3'd6: m_din = m_snap[23:16];
        3'd7: m_din = m_snap[31:24];
        default: m_din = 8'h00;
      endcase
    end
    if (!hv0 && rxv) begin m_held = rxd; m_hv = 1'b1; end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz < D || pop) m_q.push_back(pd);
      else m_ovf = 1'b1;
    end
    if (w && rg && off == 3'd4) m_stop = 1'b1;
    m_cyc++;
    m_first = 1'b0;
    nstep++;
    #1 check_all($sformatf("step%0d", nstep));
    @(negedge clk_in);
  endtask

  task automatic do_reset;
    @(negedge clk_in);
    rst_n_in = 1'b0; mem_wr = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    m_q.delete();
    m_din = 8'h00; m_hv = 1'b0; m_stop = 1'b0; m_ovf = 1'b0; m_cyc = 32'd0; m_snap = 32'd0;
    #1 check_all("reset");
    chk("reset:rx_ready_hi", {31'd0, rx_ready}, 32'd1);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    m_first = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  d;
    logic        w;
    int          k;
    do_reset();
    // RAM write then read, then aliased read
    step(32'h0000_0010, 8'hA5, 1'b1);
    step(32'h0000_0010, 8'h00, 1'b0);
    chk("ram_readback", {24'd0, mem_din}, 32'hA5);
    step(32'h0000_0020, 8'h3C, 1'b1);
    step(32'h0002_0010, 8'h00, 1'b0);
    chk("ram_alias", {24'd0, mem_din}, 32'hA5);
    step(32'h0000_0020, 8'h77, 1'b1);
    chk("hold_after_write", {24'd0, mem_din}, 32'hA5);
    // TX FIFO filling, zero-byte ignore, almost-full and overflow
    do_reset();
    step(32'h0003_0000, 8'h48, 1'b1);
    step(32'h0003_0000, 8'h69, 1'b1);
    step(32'h0003_0000, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step(32'h0003_0000, 8'h61 + 8'(i), 1'b1);
    chk("buffer_full_at_6", {31'd0, io_buffer_full}, 32'd1);
    step(32'h0003_0000, 8'h71, 1'b1);
    step(32'h0003_0000, 8'h72, 1'b1);
    chk("no_overflow_at_8", {31'd0, tx_overflow}, 32'd0);
    step(32'h0003_0000, 8'h73, 1'b1);
    chk("overflow_9th", {31'd0, tx_overflow}, 32'd1);
    step(32'h0003_0000, 8'h74, 1'b1, 1'b1);
    chk("full_push_pop", {31'd0, tx_valid}, 32'd1);
    for (int i = 0; i < 10; i++) step(32'h0003_0010, 8'h00, 1'b0, 1'b1);
    chk("drained", {31'd0, tx_valid}, 32'd0);
    // RX holding register
    step(32'h0003_0010, 8'h00, 1'b0, 1'b0, 8'h42, 1'b1);
    chk("rx_held", {31'd0, rx_ready}, 32'd0);
    step(32'h0003_0000, 8'h00, 1'b0);
    chk("rx_read", {24'd0, mem_din}, 32'h42);
    step(32'h0003_0000, 8'h00, 1'b0);
    chk("rx_read_empty", {24'd0, mem_din}, 32'h00);
    chk("rx_ready_again", {31'd0, rx_ready}, 32'd1);
    // Cycle counter snapshot across the wrap point
    @(negedge clk_in);
    m_cyc++;
    force dut.cyc = 32'hFFFF_FFFE;
    #1 release dut.cyc;
    m_cyc = 32'hFFFF_FFFE;
    for (int i = 4; i < 8; i++) step(32'h0003_0000 | 32'(i), 8'h00, 1'b0);
    chk("snap_byte3", {24'd0, mem_din}, 32'hFF);
    for (int i = 4; i < 8; i++) step(32'h0003_0000 | 32'(i), 8'h00, 1'b0);
    chk("snap_after_wrap_b3", {24'd0, mem_din}, 32'h00);
    // Program stop
    step(32'h0003_0004, 8'h99, 1'b1);
    chk("stop_set", {31'd0, program_stop}, 32'd1);
    chk("stop_zero_tx", {24'd0, tx_data}, 32'h00);
    step(32'h0003_0000, 8'h58, 1'b1);
    step(32'h0003_0010, 8'h00, 1'b0, 1'b1);
    chk("no_tx_after_stop", {31'd0, tx_valid}, 32'd0);
    step(32'h0000_0030, 8'h5A, 1'b1);
    step(32'h0000_0030, 8'h00, 1'b0);
    chk("ram_after_stop", {24'd0, mem_din}, 32'h5A);
    // Reset mid-operation: RAM kept, FIFO dropped, first read ignored
    step(32'h0000_0005, 8'h55, 1'b1);
    step(32'h0003_0000, 8'h61, 1'b1);
    do_reset();
    step(32'h0000_0005, 8'h00, 1'b0);
    chk("first_read_ignored", {24'd0, mem_din}, 32'h00);
    step(32'h0000_0005, 8'h00, 1'b0);
    chk("ram_survives_reset", {24'd0, mem_din}, 32'h55);
    // Random traffic over a small initialised RAM window and the I/O page
    for (int i = 0; i < 16; i++) step(32'h40 + 32'(i), 8'($urandom), 1'b1);
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      w = ($urandom_range(0, 2) == 0);
      d = 8'($urandom);
      if (k <= 4) a = {14'($urandom), 1'($urandom), 13'd0, 4'($urandom)} | 32'h40;
      else if (k <= 6) a = {14'($urandom), 18'h30000};
      else if (k == 7) begin a = {14'($urandom), 15'h6000, 1'b1, 2'($urandom)}; w = 1'b0; end
      else if (k == 8) a = {14'($urandom), 15'h6000, 1'b0, 2'($urandom_range(1, 3))};
      else a = {14'($urandom), 2'b11, 16'($urandom_range(8, 65535))};
      step(a, d, w, 1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
